// File: rtl/commit_monitor.sv
// commit_monitor: run monitor beside the CPU core. It watches the PC for a
// halt (PC stuck) or a cycle timeout, counts RUN cycles and accepted commits,
// and streams filtered register-file writes through a show-ahead trace FIFO.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_RUN     | program running: counting cycles, capturing trace writes
// S_DONE    | halt detected (PC unchanged for HALT_CYCLES edges), sticky
// S_TIMEOUT | TIMEOUT_CYCLES elapsed without halt, sticky
module commit_monitor #(
  parameter int          XLEN           = 32,
  parameter int          PC_W           = 32,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] WATCH_MASK     = 32'hFFFF_FFFE,
  parameter int          HALT_CYCLES    = 4,
  parameter int          TIMEOUT_CYCLES = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] pc_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_data,
  output logic [31:0]     trace_cycle,
  output logic [31:0]     cycle_count,
  output logic [31:0]     commit_count,
  output logic            running,
  output logic            done,
  output logic            timed_out,
  output logic            overflow
);

  localparam int          AW           = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LP_HALT_LAST = 32'(HALT_CYCLES - 1);
  localparam logic [31:0] LP_TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_enter_run;
  logic   w_in_run;
  logic   w_pc_same;
  logic   w_halt;
  logic   w_tmo;

  logic [PC_W-1:0] r_pc_prev;
  logic [31:0]     r_same_cnt;
  logic [31:0]     r_cycle_cnt;
  logic [31:0]     r_commit_cnt;
  logic            r_overflow;

  logic [4:0]      r_mem_rd    [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_data  [FIFO_DEPTH];
  logic [31:0]     r_mem_cycle [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;

  assign w_pc_same = (pc_in == r_pc_prev);
  assign w_halt    = w_pc_same && (r_same_cnt == LP_HALT_LAST);
  assign w_tmo     = (r_cycle_cnt == LP_TMO_LAST);

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && trace_ready;
  assign w_push_req = w_in_run && wb_en && (wb_rd != 5'd0) && WATCH_MASK[wb_rd];
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; halt takes priority over timeout on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    w_in_run    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_in_run = 1'b1;
        if (w_halt)     w_state_nxt = S_DONE;
        else if (w_tmo) w_state_nxt = S_TIMEOUT;
      end
      default: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_enter_run = 1'b1;
        end
      end
    endcase
  end

  // Cycle counter and PC-stuck tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_same_cnt  <= '0;
      r_pc_prev   <= '0;
    end else if (w_enter_run) begin
      r_cycle_cnt <= '0;
      r_same_cnt  <= '0;
      r_pc_prev   <= pc_in;
    end else if (w_in_run) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      r_same_cnt  <= w_pc_same ? r_same_cnt + 32'd1 : 32'd0;
      r_pc_prev   <= pc_in;
    end
  end

  // Accepted-commit counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst || w_enter_run) begin
      r_commit_cnt <= '0;
      r_overflow   <= 1'b0;
    end else if (w_push) begin
      r_commit_cnt <= r_commit_cnt + 32'd1;
    end else if (w_push_req) begin
      r_overflow <= 1'b1;
    end
  end

  // FIFO pointers; a new run flushes whatever was left undrained.
  always_ff @(posedge clk) begin
    if (rst || w_enter_run) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; capture stamps the pre-increment cycle count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr[AW-1:0]]    <= wb_rd;
      r_mem_data[r_wr_ptr[AW-1:0]]  <= wb_data;
      r_mem_cycle[r_wr_ptr[AW-1:0]] <= r_cycle_cnt;
    end
  end

  // Head fields are forced to zero when empty so nothing stale leaks out.
  assign trace_valid  = !w_empty;
  assign trace_rd     = trace_valid ? r_mem_rd[r_rd_ptr[AW-1:0]]    : '0;
  assign trace_data   = trace_valid ? r_mem_data[r_rd_ptr[AW-1:0]]  : '0;
  assign trace_cycle  = trace_valid ? r_mem_cycle[r_rd_ptr[AW-1:0]] : '0;

  assign cycle_count  = r_cycle_cnt;
  assign commit_count = r_commit_cnt;
  assign running      = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign timed_out    = (r_state == S_TIMEOUT);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed scenarios with literal expectations,
// then a randomized phase, all checked every cycle against a queue model.
module tb_commit_monitor;

  localparam int          XLEN  = 32;
  localparam int          PC_W  = 32;
  localparam int          DEPTH = 4;
  localparam int          HALT  = 4;
  localparam int          TMO   = 10;
  localparam logic [31:0] WMASK = 32'h7FFF_0FFE;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PC_W-1:0] pc_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            trace_valid;
  logic            trace_ready;
  logic [4:0]      trace_rd;
  logic [XLEN-1:0] trace_data;
  logic [31:0]     trace_cycle;
  logic [31:0]     cycle_count;
  logic [31:0]     commit_count;
  logic            running;
  logic            done;
  logic            timed_out;
  logic            overflow;

  commit_monitor #(
    .XLEN(XLEN), .PC_W(PC_W), .FIFO_DEPTH(DEPTH), .WATCH_MASK(WMASK),
    .HALT_CYCLES(HALT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_cycle(trace_cycle),
    .cycle_count(cycle_count), .commit_count(commit_count),
    .running(running), .done(done), .timed_out(timed_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [31:0]     cyc;
  } entry_t;

  entry_t          mq[$];
  int              m_mode    = 0;   // 0 idle, 1 run, 2 done, 3 timeout
  logic [31:0]     m_cyc     = '0;
  logic [31:0]     m_com     = '0;
  logic [31:0]     m_same    = '0;
  logic [PC_W-1:0] m_pc_prev = '0;
  logic            m_ovf     = 1'b0;
  logic [31:0]     wmask_v   = WMASK;

  always @(posedge clk) begin : model
    bit     pop_now;
    bit     cap;
    bit     halt;
    bit     tmo;
    entry_t e;
    if (rst) begin
      mq.delete();
      m_mode = 0; m_cyc = 0; m_com = 0; m_same = 0; m_pc_prev = 0; m_ovf = 0;
    end else if (m_mode != 1) begin
      if (start) begin
        mq.delete();
        m_mode = 1; m_cyc = 0; m_com = 0; m_same = 0; m_ovf = 0;
        m_pc_prev = pc_in;
      end else if (mq.size() > 0 && trace_ready) begin
        void'(mq.pop_front());
      end
    end else begin
      pop_now = (mq.size() > 0) && trace_ready;
      cap     = wb_en && (wb_rd != 5'd0) && wmask_v[wb_rd];
      if (pop_now) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) begin
          e.rd = wb_rd; e.data = wb_data; e.cyc = m_cyc;
          mq.push_back(e);
          m_com = m_com + 1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      halt = (pc_in == m_pc_prev) && (m_same == 32'(HALT - 1));
      tmo  = (m_cyc == 32'(TMO - 1));
      m_same    = (pc_in == m_pc_prev) ? m_same + 1 : 32'd0;
      m_pc_prev = pc_in;
      m_cyc     = m_cyc + 1;
      if (halt)     m_mode = 2;
      else if (tmo) m_mode = 3;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("valid", 64'(trace_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("head_rd",    64'(trace_rd),    64'(mq[0].rd));
      chk("head_data",  64'(trace_data),  64'(mq[0].data));
      chk("head_cycle", 64'(trace_cycle), 64'(mq[0].cyc));
    end
    chk("cycle_count",  64'(cycle_count),  64'(m_cyc));
    chk("commit_count", 64'(commit_count), 64'(m_com));
    chk("running",      64'(running),      64'(m_mode == 1));
    chk("done",         64'(done),         64'(m_mode == 2));
    chk("timed_out",    64'(timed_out),    64'(m_mode == 3));
    chk("overflow",     64'(overflow),     64'(m_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hseq [7] = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12};

  initial begin
    // Reset with activity on the inputs.
    rst = 1'b1; start = 1'b0; pc_in = 0; wb_en = 1'b1; wb_rd = 5'd1;
    wb_data = 32'hAA; trace_ready = 1'b0;
    step(); pc_in = 4; step();
    chk("lit_rst_valid",  64'(trace_valid),  64'(0));
    chk("lit_rst_rd",     64'(trace_rd),     64'(0));
    chk("lit_rst_data",   64'(trace_data),   64'(0));
    chk("lit_rst_tcyc",   64'(trace_cycle),  64'(0));
    chk("lit_rst_cycle",  64'(cycle_count),  64'(0));
    chk("lit_rst_commit", 64'(commit_count), 64'(0));
    chk("lit_rst_run",    64'(running),      64'(0));
    chk("lit_rst_done",   64'(done),         64'(0));
    chk("lit_rst_tmo",    64'(timed_out),    64'(0));
    chk("lit_rst_ovf",    64'(overflow),     64'(0));
    rst = 1'b0; step();
    chk("lit_nocap_valid",  64'(trace_valid),  64'(0));
    chk("lit_nocap_commit", 64'(commit_count), 64'(0));

    // Trace filter: x1=5, x0=9 (ignored), x2=7.
    wb_en = 1'b0; start = 1'b1; pc_in = 0; trace_ready = 1'b1; step();
    start = 1'b0;
    chk("lit_tr_running", 64'(running), 64'(1));
    pc_in = 1; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; step();
    chk("lit_tr_v0",  64'(trace_valid), 64'(1));
    chk("lit_tr_rd0", 64'(trace_rd),    64'(1));
    chk("lit_tr_d0",  64'(trace_data),  64'(5));
    chk("lit_tr_c0",  64'(trace_cycle), 64'(0));
    pc_in = 2; wb_rd = 5'd0; wb_data = 32'd9; step();
    chk("lit_tr_x0_dropped", 64'(trace_valid), 64'(0));
    pc_in = 3; wb_rd = 5'd2; wb_data = 32'd7; step();
    chk("lit_tr_rd1",    64'(trace_rd),     64'(2));
    chk("lit_tr_d1",     64'(trace_data),   64'(7));
    chk("lit_tr_c1",     64'(trace_cycle),  64'(2));
    chk("lit_tr_commit", 64'(commit_count), 64'(2));

    // Keep PC moving until timeout.
    wb_en = 1'b0; pc_in = 4;
    for (int i = 0; i < 20 && !timed_out; i++) begin
      pc_in = pc_in + 1; step();
    end
    chk("lit_to_flag",  64'(timed_out),   64'(1));
    chk("lit_to_cycle", 64'(cycle_count), 64'(10));
    chk("lit_to_done",  64'(done),        64'(0));
    chk("lit_to_run",   64'(running),     64'(0));

    // Halt: 0,4,8,12 then hold; two writes left undrained.
    trace_ready = 1'b0; start = 1'b1; pc_in = 0; step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pc_in   = hseq[i];
      wb_en   = (i == 3 || i == 4);
      wb_rd   = (i == 3) ? 5'd5 : 5'd6;
      wb_data = 32'h50 + 32'(i);
      step();
      if (i == 5) begin
        chk("lit_halt_early_done", 64'(done),    64'(0));
        chk("lit_halt_early_run",  64'(running), 64'(1));
      end
    end
    wb_en = 1'b0;
    chk("lit_halt_done",   64'(done),         64'(1));
    chk("lit_halt_run",    64'(running),      64'(0));
    chk("lit_halt_tmo",    64'(timed_out),    64'(0));
    chk("lit_halt_cycle",  64'(cycle_count),  64'(7));
    chk("lit_halt_commit", 64'(commit_count), 64'(2));
    chk("lit_halt_head",   64'(trace_rd),     64'(5));

    // Restart flushes the two leftover entries.
    start = 1'b1; pc_in = 0; step();
    start = 1'b0;
    chk("lit_rs_valid",  64'(trace_valid),  64'(0));
    chk("lit_rs_commit", 64'(commit_count), 64'(0));
    chk("lit_rs_cycle",  64'(cycle_count),  64'(0));
    chk("lit_rs_done",   64'(done),         64'(0));
    chk("lit_rs_run",    64'(running),      64'(1));

    // Overflow: six writes to x3 into a depth-4 FIFO, then drain.
    wb_en = 1'b1; wb_rd = 5'd3;
    for (int i = 0; i < 6; i++) begin
      pc_in = 32'd100 + 32'(i * 4); wb_data = 32'd100 + 32'(i); step();
    end
    wb_en = 1'b0;
    chk("lit_ov_commit", 64'(commit_count), 64'(4));
    chk("lit_ov_flag",   64'(overflow),     64'(1));
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_ov_drain_data", 64'(trace_data),  64'(100 + i));
      chk("lit_ov_drain_cyc",  64'(trace_cycle), 64'(i));
      pc_in = pc_in + 4; step();
    end
    chk("lit_ov_empty", 64'(trace_valid), 64'(0));

    // Halt and timeout on the same edge: halt wins.
    trace_ready = 1'b0; start = 1'b1; pc_in = 0; step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pc_in = (i < 6) ? 32'(i + 1) : 32'd6; step();
    end
    chk("lit_both_done",  64'(done),        64'(1));
    chk("lit_both_tmo",   64'(timed_out),   64'(0));
    chk("lit_both_cycle", 64'(cycle_count), 64'(10));

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) pc_in = $urandom_range(0, 7);
      wb_en       = $urandom_range(0, 1) == 1;
      wb_rd       = 5'($urandom_range(0, 31));
      wb_data     = $urandom;
      trace_ready = ($urandom_range(0, 9) < 4);
      step();
    end
    rst = 1'b0; start = 1'b0; wb_en = 1'b0; trace_ready = 1'b1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Parametrised, synthesisable run monitor for the pipelined CPU. It taps the register-file write-back port and the program counter. It detects end-of-program (PC stuck) or a cycle timeout, counts cycles and commits, and streams a filtered trace of register writes through a FIFO with a valid/ready read port. It sits beside `top`, so benches and on-board debug logic drain results instead of polling register-file internals with fixed delays.

## Interface
Parameters:
- XLEN, 32, write-back data width
- PC_W, 32, program-counter width
- FIFO_DEPTH, 16, trace entries; power of two, ≥2
- WATCH_MASK, 32'hFFFF_FFFE, bit n=1 traces writes to xn; bit 0 ignored
- HALT_CYCLES, 4, consecutive unchanged-PC cycles that mean halt; ≥1
- TIMEOUT_CYCLES, 100, RUN cycles before forced timeout; ≥1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- start  in  1  pulse to begin/restart a run
- pc_in  in  PC_W  current PC from the fetch stage
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write destination
- wb_data  in  XLEN  write data
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer pops head when trace_valid&&trace_ready
- trace_rd  out  5  head destination register
- trace_data  out  XLEN  head data
- trace_cycle  out  32  cycle_count when the head entry was captured
- cycle_count  out  32  RUN cycles elapsed
- commit_count  out  32  traced writes accepted into FIFO
- running  out  1  state==RUN
- done  out  1  halt detected (sticky)
- timed_out  out  1  timeout hit (sticky)
- overflow  out  1  at least one trace write dropped (sticky)

## Operation
- States: IDLE, RUN, DONE, TIMEOUT. A rst edge forces IDLE, empties the FIFO and zeroes all counters, flags, pc_prev and same_cnt.
- Reset values: every output 0.
- IDLE --start--> RUN. DONE/TIMEOUT --start--> RUN. start in RUN is ignored.
- On any start edge that enters RUN:
  - cycle_count, commit_count and same_cnt are cleared.
  - done, timed_out and overflow are cleared.
  - The FIFO is flushed.
  - pc_prev is loaded with pc_in.
- RUN, each edge:
  - cycle_count += 1.
  - If pc_in==pc_prev, same_cnt += 1; otherwise same_cnt=0.
  - pc_prev is loaded with pc_in.
- RUN->DONE: on the edge where pc_in==pc_prev and same_cnt==HALT_CYCLES-1.
- RUN->TIMEOUT: on the edge where cycle_count==TIMEOUT_CYCLES-1.
- If both conditions hold on the same edge, DONE wins; timed_out stays 0.
- Capture: in RUN only (including the exiting edge), when wb_en && wb_rd!=0 && WATCH_MASK[wb_rd]. The entry {wb_rd, wb_data, cycle_count(pre-increment)} is pushed.
- Push accepted if the FIFO is not full, or if a pop happens on the same edge. Otherwise the write is dropped and overflow is set; commit_count counts accepted pushes only.
- Pops are allowed in every state, including IDLE/DONE/TIMEOUT. Draining after the run ends is the normal flow.
- Counters are 32-bit wrap-around. Pointers are log2(FIFO_DEPTH)+1 bits, with full/empty taken from the MSB compare.

## Timing
- Show-ahead FIFO. An entry pushed at edge k has trace_valid=1 after edge k when the FIFO was empty; capture-to-visible latency is 1 cycle.
- The pop takes effect at the edge where trace_valid&&trace_ready; the next head or trace_valid=0 appears after that edge.
- trace_rd, trace_data and trace_cycle are stable while trace_valid=1 and trace_ready=0.
- done and timed_out assert after the transition edge and hold until start or rst. running falls on the same edge.
- Simultaneous push+pop on an empty FIFO: the pop is invalid and the push succeeds.
- Simultaneous push+pop on a full FIFO: both succeed, no overflow.
- rst mid-run discards all trace entries on that edge.

## Test plan
- Reset: rst=1 for 2 edges with pc_in toggling and wb_en=1 → every output 0, state IDLE; no capture before start.
- Halt (HALT_CYCLES=4): start, PC steps 0,4,8,12, then holds at 12 → done=1 after the 4th consecutive equal-PC edge; timed_out=0; running=0 on that same edge.
- Trace/filter: with trace_ready=1, write x1=5 at cycle 0, x0=9 at cycle 1, x2=7 at cycle 2 → entries (1,5,0), (2,7,2) only; commit_count=2.
- Overflow (FIFO_DEPTH=4, trace_ready=0): 6 writes to x3 → 4 retained, overflow=1, commit_count=4. Then trace_ready=1 → values drain in order; trace_valid=0 after the 4th pop.
- Timeout (TIMEOUT_CYCLES=10): PC increments every cycle → timed_out=1 with cycle_count=10. Timeout and halt on the same edge → done=1, timed_out=0.
- Restart: after DONE with 2 undrained entries, pulse start → FIFO empty, counters and flags 0, running=1.
